// File: rtl/lcd_pkg.sv
// Shared constants and types for the 2x16 LCD text buffer.
// Holds the ASCII control codes, screen geometry and the controller state encoding.
package lcd_pkg;

    localparam int LCD_COLS  = 16;
    localparam int LCD_ROWS  = 2;
    localparam int LCD_CELLS = LCD_COLS * LCD_ROWS;

    localparam logic [7:0] CHR_BS = 8'h08;
    localparam logic [7:0] CHR_LF = 8'h0A;
    localparam logic [7:0] CHR_FF = 8'h0C;
    localparam logic [7:0] CHR_CR = 8'h0D;

    typedef enum logic [1:0] {
        ST_INIT_CLR = 2'd0,
        ST_IDLE     = 2'd1,
        ST_CLR      = 2'd2,
        ST_SCROLL   = 2'd3
    } lcd_state_e;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/lcd_text_buffer_if.sv
// Producer byte stream (valid/ready) and LCD driver read port of the text buffer.
// The master drives bytes and read addresses; the slave is the buffer itself.
interface lcd_text_buffer_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] rd_addr;
    logic       rd_en;
    logic [7:0] rd_data;

    modport master (
        output in_data, in_valid, rd_addr, rd_en,
        input  in_ready, rd_data
    );

    modport slave (
        input  in_data, in_valid, rd_addr, rd_en,
        output in_ready, rd_data
    );

endinterface

// File: rtl/lcd_text_ram.sv
// 32x8 character store: one synchronous write port with an optional companion
// blanking of the row-1 cell in the same column, and two asynchronous read ports.
module lcd_text_ram
    import lcd_pkg::*;
#(
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       we_i,
    input  logic [4:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic       blank_hi_i,
    input  logic [4:0] raddr_a_i,
    output logic [7:0] rdata_a_o,
    input  logic [4:0] raddr_b_i,
    output logic [7:0] rdata_b_o
);

    logic [7:0] mem_q [LCD_CELLS];

    // Scroll moves a row-1 cell up and blanks it in the same cycle, hence the second write.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (blank_hi_i) begin
            mem_q[{1'b1, waddr_i[3:0]}] <= BLANK_CHAR;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/lcd_text_buffer.sv
// 2x16 character frame buffer: terminal-style byte input with cursor, wrap,
// newline, scroll and clear; zero-latency read port at LCD DDRAM addresses.
module lcd_text_buffer
    import lcd_pkg::*;
#(
    parameter logic [7:0] BLANK_CHAR = 8'h20,
    parameter logic [7:0] LINE1_BASE = 8'h40,
    parameter bit         SCROLL_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    lcd_text_buffer_if.slave   bus,
    output logic               cursor_row,
    output logic [3:0]         cursor_col,
    output logic               busy
);

    lcd_state_e state_q;
    logic [4:0] cnt_q;
    logic       row_q;
    logic [3:0] col_q;
    logic       ready_q;
    logic       busy_q;

    logic       xfer_s;
    logic       newline_s;
    logic       we_s;
    logic [4:0] waddr_s;
    logic [7:0] wdata_s;
    logic       blank_hi_s;
    logic [7:0] scroll_src_s;
    logic [7:0] ram_rd_s;
    logic [7:0] line1_off_s;
    logic       rd_hit_s;
    logic [4:0] rd_idx_s;
    logic       unused_rd_en_s;

    assign xfer_s         = bus.in_valid & ready_q;
    assign newline_s      = (bus.in_data == CHR_LF)
                          | (is_printable(bus.in_data) & (col_q == 4'd15));
    assign unused_rd_en_s = bus.rd_en;

    // Select the single RAM write of this cycle from the current state.
    always_comb begin
        we_s       = 1'b0;
        waddr_s    = 5'd0;
        wdata_s    = BLANK_CHAR;
        blank_hi_s = 1'b0;
        case (state_q)
            ST_INIT_CLR, ST_CLR: begin
                we_s    = ~reset;
                waddr_s = cnt_q;
            end
            ST_SCROLL: begin
                we_s       = ~reset;
                blank_hi_s = ~reset;
                waddr_s    = {1'b0, cnt_q[3:0]};
                wdata_s    = scroll_src_s;
            end
            ST_IDLE: begin
                we_s    = xfer_s & is_printable(bus.in_data) & ~reset;
                waddr_s = {row_q, col_q};
                wdata_s = bus.in_data;
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    // Map a DDRAM address to a cell index; anything outside both rows reads as blank.
    assign line1_off_s = bus.rd_addr - LINE1_BASE;
    always_comb begin
        rd_hit_s = 1'b0;
        rd_idx_s = 5'd0;
        if (bus.rd_addr < 8'd16) begin
            rd_hit_s = 1'b1;
            rd_idx_s = {1'b0, bus.rd_addr[3:0]};
        end else if ((bus.rd_addr >= LINE1_BASE) && (line1_off_s < 8'd16)) begin
            rd_hit_s = 1'b1;
            rd_idx_s = {1'b1, line1_off_s[3:0]};
        end else begin
            rd_hit_s = 1'b0;
        end
    end

    assign bus.rd_data = rd_hit_s ? ram_rd_s : BLANK_CHAR;

    lcd_text_ram #(
        .BLANK_CHAR (BLANK_CHAR)
    ) u_ram (
        .clk        (clk),
        .we_i       (we_s),
        .waddr_i    (waddr_s),
        .wdata_i    (wdata_s),
        .blank_hi_i (blank_hi_s),
        .raddr_a_i  (rd_idx_s),
        .rdata_a_o  (ram_rd_s),
        .raddr_b_i  ({1'b1, cnt_q[3:0]}),
        .rdata_b_o  (scroll_src_s)
    );

    // Controller FSM, sequence counter, cursor and registered handshake/status.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT_CLR;
            cnt_q   <= 5'd0;
            row_q   <= 1'b0;
            col_q   <= 4'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT_CLR, ST_CLR: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= ST_IDLE;
                        row_q   <= 1'b0;
                        col_q   <= 4'd0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_SCROLL: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd15) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= 5'd0;
                        row_q   <= 1'b1;
                        col_q   <= 4'd0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    cnt_q <= 5'd0;
                    if (xfer_s) begin
                        if (newline_s) begin
                            if (!row_q) begin
                                row_q <= 1'b1;
                                col_q <= 4'd0;
                            end else if (SCROLL_EN) begin
                                state_q <= ST_SCROLL;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b1;
                            end else begin
                                row_q <= 1'b0;
                                col_q <= 4'd0;
                            end
                        end else if (is_printable(bus.in_data)) begin
                            col_q <= col_q + 4'd1;
                        end else begin
                            case (bus.in_data)
                                CHR_CR: col_q <= 4'd0;
                                CHR_BS: begin
                                    if (col_q != 4'd0) begin
                                        col_q <= col_q - 4'd1;
                                    end
                                end
                                CHR_FF: begin
                                    state_q <= ST_CLR;
                                    ready_q <= 1'b0;
                                    busy_q  <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                default: begin
                    state_q <= ST_INIT_CLR;
                    cnt_q   <= 5'd0;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready = ready_q;
    assign busy         = busy_q;
    assign cursor_row   = row_q;
    assign cursor_col   = col_q;

endmodule
